// File: rtl/apb_mtimer_pkg.sv
// apb_mtimer_pkg: register map, CTRL layout and shared types for apb_mtimer_multi.
package apb_mtimer_pkg;

    localparam int MaxCmp = 8;

    localparam logic [5:0] WordMtimeLo    = 6'h00;
    localparam logic [5:0] WordMtimeHi    = 6'h01;
    localparam logic [5:0] WordCtrl       = 6'h02;
    localparam logic [5:0] WordStatus     = 6'h03;
    localparam logic [5:0] WordCmpBase    = 6'h04;
    localparam logic [5:0] WordReloadBase = 6'h14;

    localparam int CtrlEnBit    = 0;
    localparam int CtrlPrescLsb = 8;
    localparam int CtrlArLsb    = 16;

    typedef struct packed {
        logic [MaxCmp-1:0] autoreload;
        logic [7:0]        prescaler;
        logic              enable;
    } ctrl_t;

    function automatic logic [5:0] cmp_word(input int ch, input logic hi);
        return WordCmpBase + 6'(2 * ch) + {5'b0, hi};
    endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// mtimer_prescaler: divides enabled cycles by (prescaler+1); clear restarts the count and
// suppresses the tick in that cycle.
module mtimer_prescaler #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic         clear,
    input  logic [W-1:0] prescaler,
    output logic         tick
);

    logic [W-1:0] cnt_q;

    assign tick = enable & ~clear & (cnt_q == prescaler);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= (clear || !enable || tick) ? '0 : cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/apb_mtimer_multi.sv
// apb_mtimer_multi: APB machine timer, 64-bit mtime with prescaler and NUM_CMP compare IRQs.
// Define MTIMER_AUTORELOAD_EN to add per-channel RELOAD registers and CTRL autoreload bits.
module apb_mtimer_multi
    import apb_mtimer_pkg::*;
#(
    parameter int NUM_CMP = 1,
    parameter int PRESC_W = 3
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               psel_i,
    input  logic               penable_i,
    input  logic               pwrite_i,
    input  logic [31:0]        paddr_i,
    input  logic [31:0]        pwdata_i,
    output logic [31:0]        prdata_o,
    output logic               pready_o,
    output logic               pslverr_o,
    output logic [63:0]        mtime_o,
    output logic [NUM_CMP-1:0] timer_irq_o
);

    localparam logic [7:0]        PrescMask = 8'((32'd1 << PRESC_W) - 1);
    localparam logic [MaxCmp-1:0] ChMask    = MaxCmp'((32'd1 << NUM_CMP) - 1);

    logic                         access, wr, rd, hit, tick, clear;
    logic                         mtime_lo_wr, mtime_hi_wr, ctrl_wr;
    logic [5:0]                   word;
    logic [31:0]                  rdata, ctrl_rd;
    logic [63:0]                  mtime_q;
    logic [31:0]                  shadow_q;
    ctrl_t                        ctrl_q;
    logic [NUM_CMP-1:0]           irq;
    logic [NUM_CMP-1:0][63:0]     cmp;
`ifdef MTIMER_AUTORELOAD_EN
    logic [NUM_CMP-1:0][31:0]     reload;
`endif
    logic                         unused_addr;

    assign access      = psel_i & penable_i;
    assign wr          = access & pwrite_i;
    assign rd          = access & ~pwrite_i;
    assign word        = paddr_i[7:2];
    assign unused_addr = ^{paddr_i[31:8], paddr_i[1:0]};
    assign mtime_lo_wr = wr & (word == WordMtimeLo);
    assign mtime_hi_wr = wr & (word == WordMtimeHi);
    assign ctrl_wr     = wr & (word == WordCtrl);
    assign clear       = ctrl_wr | mtime_lo_wr | mtime_hi_wr;
    assign ctrl_rd     = 32'({ctrl_q.autoreload, ctrl_q.prescaler, 7'b0, ctrl_q.enable});

    mtimer_prescaler #(.W(PRESC_W)) u_presc (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .enable    (ctrl_q.enable),
        .clear     (clear),
        .prescaler (ctrl_q.prescaler[PRESC_W-1:0]),
        .tick      (tick)
    );

    // A write to either mtime half takes priority over the tick in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mtime_q  <= '0;
            ctrl_q   <= '0;
            shadow_q <= '0;
        end else begin
            if (mtime_lo_wr) mtime_q[31:0] <= pwdata_i;
            else if (mtime_hi_wr) mtime_q[63:32] <= pwdata_i;
            else if (tick) mtime_q <= mtime_q + 64'd1;
            if (ctrl_wr) begin
                ctrl_q.enable    <= pwdata_i[CtrlEnBit];
                ctrl_q.prescaler <= pwdata_i[CtrlPrescLsb +: 8] & PrescMask;
`ifdef MTIMER_AUTORELOAD_EN
                ctrl_q.autoreload <= pwdata_i[CtrlArLsb +: MaxCmp] & ChMask;
`endif
            end
            if (rd && word == WordMtimeLo) shadow_q <= mtime_q[63:32];
        end
    end

    for (genvar g = 0; g < NUM_CMP; g++) begin : g_ch
        localparam logic [5:0] LoWord = cmp_word(g, 1'b0);
        localparam logic [5:0] HiWord = cmp_word(g, 1'b1);
        logic [63:0] cmp_q;
        assign irq[g] = ctrl_q.enable & (mtime_q >= cmp_q);
        assign cmp[g] = cmp_q;
`ifdef MTIMER_AUTORELOAD_EN
        logic [31:0] reload_q;
        assign reload[g] = reload_q;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) reload_q <= '0;
            else if (wr && word == WordReloadBase + 6'(g)) reload_q <= pwdata_i;
        end
`endif
        // Bus writes win over the autoreload advance.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) cmp_q <= '1;
            else if (wr && word == LoWord) cmp_q[31:0] <= pwdata_i;
            else if (wr && word == HiWord) cmp_q[63:32] <= pwdata_i;
`ifdef MTIMER_AUTORELOAD_EN
            else if (irq[g] && ctrl_q.autoreload[g]) cmp_q <= cmp_q + {32'd0, reload_q};
`endif
        end
    end

    always_comb begin
        rdata = '0;
        hit   = 1'b0;
        if (word == WordMtimeLo) begin hit = 1'b1; rdata = mtime_q[31:0]; end
        if (word == WordMtimeHi) begin hit = 1'b1; rdata = shadow_q; end
        if (word == WordCtrl)    begin hit = 1'b1; rdata = ctrl_rd; end
        if (word == WordStatus)  begin hit = 1'b1; rdata = 32'(irq); end
        for (int i = 0; i < NUM_CMP; i++) begin
            if (word == cmp_word(i, 1'b0)) begin hit = 1'b1; rdata = cmp[i][31:0]; end
            if (word == cmp_word(i, 1'b1)) begin hit = 1'b1; rdata = cmp[i][63:32]; end
`ifdef MTIMER_AUTORELOAD_EN
            if (word == WordReloadBase + 6'(i)) begin hit = 1'b1; rdata = reload[i]; end
`endif
        end
    end

    assign prdata_o    = (rd && hit) ? rdata : '0;
    assign pready_o    = access;
    assign pslverr_o   = access & ~hit;
    assign mtime_o     = mtime_q;
    assign timer_irq_o = irq;

endmodule

// File: tb/tb_apb_mtimer_multi.sv
// tb_apb_mtimer_multi: directed self-checking bench for apb_mtimer_multi with two channels.
module tb_apb_mtimer_multi;

    logic        clk = 1'b0;
    logic        rst_n, psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic        pready, pslverr;
    logic [63:0] mtime;
    logic [1:0]  irq;
    int          passed = 0;
    int          total = 0;

    always #5 clk = ~clk;

    apb_mtimer_multi #(.NUM_CMP(2), .PRESC_W(3)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .psel_i      (psel),
        .penable_i   (penable),
        .pwrite_i    (pwrite),
        .paddr_i     (paddr),
        .pwdata_i    (pwdata),
        .prdata_o    (prdata),
        .pready_o    (pready),
        .pslverr_o   (pslverr),
        .mtime_o     (mtime),
        .timer_irq_o (irq)
    );

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output logic err);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        #1 err = pslverr;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic err);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(negedge clk);
        penable = 1'b1;
        #1 d = prdata; err = pslverr;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic        e;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (mtime !== 64'd0) $display("FAIL reset_mtime got %h want 0", mtime); else passed++;
        total++; if (irq !== 2'b00) $display("FAIL reset_irq got %b want 00", irq); else passed++;
        rst_n = 1'b1;
        apb_read(32'h08, d, e);
        total++; if (d !== 32'h0) $display("FAIL reset_ctrl got %h want 0", d); else passed++;
        apb_read(32'h10, d, e);
        total++; if (d !== 32'hFFFF_FFFF) $display("FAIL reset_cmp0_lo got %h want ffffffff", d); else passed++;
        apb_read(32'h1C, d, e);
        total++; if (d !== 32'hFFFF_FFFF || e !== 1'b0) $display("FAIL reset_cmp1_hi got %h err %b want ffffffff err 0", d, e); else passed++;
    endtask

    task automatic test_prescaler;
        logic [31:0] d;
        logic        e;
        apb_write(32'h08, 32'h0000_0301, e);
        repeat (39) @(posedge clk);
        #1;
        total++; if (mtime !== 64'd9) $display("FAIL presc_39clk got %0d want 9", mtime); else passed++;
        @(posedge clk);
        #1;
        total++; if (mtime !== 64'd10) $display("FAIL presc_40clk got %0d want 10", mtime); else passed++;
        apb_read(32'h08, d, e);
        total++; if (d !== 32'h0000_0301) $display("FAIL ctrl_readback got %h want 00000301", d); else passed++;
        apb_write(32'h08, 32'h0000_0001, e);
        apb_write(32'h00, 32'h0000_0100, e);
        total++; if (mtime !== 64'h100) $display("FAIL write_beats_tick got %h want 100", mtime); else passed++;
        @(posedge clk);
        #1;
        total++; if (mtime !== 64'h101) $display("FAIL tick_after_write got %h want 101", mtime); else passed++;
        apb_write(32'h08, 32'hFFFF_FFFF, e);
        apb_read(32'h08, d, e);
`ifdef MTIMER_AUTORELOAD_EN
        total++; if (d !== 32'h0003_0701) $display("FAIL ctrl_mask got %h want 00030701", d); else passed++;
`else
        total++; if (d !== 32'h0000_0701) $display("FAIL ctrl_mask got %h want 00000701", d); else passed++;
`endif
        apb_write(32'h08, 32'h0, e);
    endtask

    task automatic test_atomic;
        logic [31:0] d;
        logic        e;
        apb_write(32'h00, 32'hFFFF_FFFF, e);
        apb_write(32'h04, 32'h0, e);
        apb_read(32'h00, d, e);
        total++; if (d !== 32'hFFFF_FFFF) $display("FAIL atomic_lo got %h want ffffffff", d); else passed++;
        apb_write(32'h08, 32'h1, e);
        repeat (8) @(posedge clk);
        apb_read(32'h04, d, e);
        total++; if (d !== 32'h0) $display("FAIL atomic_hi_shadow got %h want 0", d); else passed++;
        total++; if (mtime[63:32] !== 32'h1) $display("FAIL atomic_live_hi got %h want 1", mtime[63:32]); else passed++;
        apb_read(32'h00, d, e);
        apb_read(32'h04, d, e);
        total++; if (d !== 32'h1) $display("FAIL atomic_hi_relatch got %h want 1", d); else passed++;
        apb_write(32'h08, 32'h0, e);
    endtask

    task automatic test_compare;
        logic [31:0] d;
        logic        e;
        logic [1:0]  exp;
        apb_write(32'h00, 32'h0, e);
        apb_write(32'h04, 32'h0, e);
        apb_write(32'h10, 32'd5, e);
        apb_write(32'h14, 32'h0, e);
        apb_write(32'h18, 32'd9, e);
        apb_write(32'h1C, 32'h0, e);
        total++; if (irq !== 2'b00) $display("FAIL cmp_disabled got %b want 00", irq); else passed++;
        apb_write(32'h08, 32'h1, e);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            exp = {k >= 9, k >= 5};
            total++; if (irq !== exp) $display("FAIL cmp_irq_mtime%0d got %b want %b", k, irq, exp); else passed++;
        end
        apb_read(32'h0C, d, e);
        total++; if (d !== 32'h3) $display("FAIL status got %h want 3", d); else passed++;
        apb_write(32'h10, 32'd100, e);
        total++; if (irq !== 2'b10) $display("FAIL cmp_raise_clears got %b want 10", irq); else passed++;
        apb_write(32'h08, 32'h0, e);
        total++; if (irq !== 2'b00) $display("FAIL cmp_disable_gates got %b want 00", irq); else passed++;
    endtask

    task automatic test_wrap;
        logic e;
        apb_write(32'h00, 32'hFFFF_FFFF, e);
        apb_write(32'h04, 32'hFFFF_FFFF, e);
        apb_write(32'h10, 32'hFFFF_FFFF, e);
        apb_write(32'h14, 32'hFFFF_FFFF, e);
        apb_write(32'h18, 32'hFFFF_FFFF, e);
        apb_write(32'h1C, 32'hFFFF_FFFF, e);
        total++; if (irq !== 2'b00) $display("FAIL wrap_disabled got %b want 00", irq); else passed++;
        apb_write(32'h08, 32'h1, e);
        total++; if (irq !== 2'b11 || mtime !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL wrap_max got irq %b mtime %h want 11 ffffffffffffffff", irq, mtime); else passed++;
        @(posedge clk);
        #1;
        total++; if (mtime !== 64'd0) $display("FAIL wrap_mtime got %h want 0", mtime); else passed++;
        total++; if (irq !== 2'b00) $display("FAIL wrap_irq got %b want 00", irq); else passed++;
        apb_write(32'h08, 32'h0, e);
    endtask

    task automatic test_unmapped;
        logic [31:0] d;
        logic        e;
        apb_write(32'h00, 32'h1234, e);
        apb_write(32'h04, 32'h0, e);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h08;
        #1;
        total++; if (prdata !== 32'h0 || pready !== 1'b0) $display("FAIL setup_phase got prdata %h pready %b want 0 0", prdata, pready); else passed++;
        @(negedge clk);
        penable = 1'b1;
        #1;
        total++; if (pready !== 1'b1 || pslverr !== 1'b0) $display("FAIL access_phase got pready %b pslverr %b want 1 0", pready, pslverr); else passed++;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        apb_read(32'h3C, d, e);
        total++; if (e !== 1'b1 || d !== 32'h0) $display("FAIL unmapped_read got err %b data %h want 1 0", e, d); else passed++;
        apb_write(32'hFC, 32'hFFFF_FFFF, e);
        total++; if (e !== 1'b1) $display("FAIL unmapped_write_fc got err %b want 1", e); else passed++;
        apb_write(32'h3C, 32'hFFFF_FFFF, e);
        total++; if (e !== 1'b1) $display("FAIL unmapped_write_3c got err %b want 1", e); else passed++;
        apb_read(32'h50, d, e);
`ifdef MTIMER_AUTORELOAD_EN
        total++; if (e !== 1'b0) $display("FAIL reload_mapped got err %b want 0", e); else passed++;
`else
        total++; if (e !== 1'b1 || d !== 32'h0) $display("FAIL reload_unmapped got err %b data %h want 1 0", e, d); else passed++;
`endif
        apb_read(32'h18, d, e);
        total++; if (e !== 1'b0 || d !== 32'hFFFF_FFFF) $display("FAIL cmp1_after_unmapped got err %b data %h want 0 ffffffff", e, d); else passed++;
        apb_read(32'h08, d, e);
        total++; if (d !== 32'h0) $display("FAIL ctrl_after_unmapped got %h want 0", d); else passed++;
        total++; if (mtime !== 64'h1234 || irq !== 2'b00) $display("FAIL state_after_unmapped got mtime %h irq %b want 1234 00", mtime, irq); else passed++;
    endtask

`ifdef MTIMER_AUTORELOAD_EN
    task automatic test_autoreload;
        logic e;
        logic exp;
        apb_write(32'h00, 32'h0, e);
        apb_write(32'h04, 32'h0, e);
        apb_write(32'h10, 32'd5, e);
        apb_write(32'h14, 32'h0, e);
        apb_write(32'h50, 32'd10, e);
        apb_write(32'h08, 32'h0001_0001, e);
        for (int k = 1; k <= 26; k++) begin
            @(posedge clk);
            #1;
            exp = (k == 5) || (k == 15) || (k == 25);
            total++; if (irq[0] !== exp) $display("FAIL reload_pulse_mtime%0d got %b want %b", k, irq[0], exp); else passed++;
        end
        apb_write(32'h08, 32'h0, e);
    endtask
`endif

    initial begin
        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        test_reset();
        test_prescaler();
        test_atomic();
        test_compare();
        test_wrap();
        test_unmapped();
`ifdef MTIMER_AUTORELOAD_EN
        test_autoreload();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
